// File: rtl/dbus_arb_pkg.sv
// Shared types and sizing helpers for the DBus arbiter slice.
package dbus_arb_pkg;

  typedef enum logic [1:0] {
    PARKED,
    GRANTED,
    HANDOVER
  } arbState_e;

  localparam int unsigned DBUS_NUM_MASTERS = 4;
  localparam int unsigned DBUS_MAX_TENURE  = 16;

  function automatic int unsigned idxWidth(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned tenureWidth(input int unsigned t);
    return (t < 2) ? 1 : $clog2(t);
  endfunction

endpackage

// File: rtl/dbus_rr_picker.sv
// Rotating-priority encoder: first requester after ptr, wrapping, with ptr itself last.
module dbus_rr_picker
  import dbus_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = DBUS_NUM_MASTERS
) (
  input  logic [NUM_MASTERS-1:0]            req,
  input  logic [idxWidth(NUM_MASTERS)-1:0]  ptr,
  output logic [idxWidth(NUM_MASTERS)-1:0]  winIdx,
  output logic                              winValid
);

  localparam int unsigned IW = idxWidth(NUM_MASTERS);

  logic [IW-1:0] candIdx;

  always_comb begin
    winIdx   = ptr;
    winValid = 1'b0;
    candIdx  = '0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      candIdx = IW'((32'(ptr) + i) % NUM_MASTERS);
      if (!winValid && req[candIdx]) begin
        winValid = 1'b1;
        winIdx   = candIdx;
      end
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Round-robin DBus arbiter with parking, lock, bounded tenure and a dead cycle per handover.
// Build option: DBUS_ARB_CPU_PRIORITY_EN lets PARK_MASTER win every decision it takes part in.
module dbus_arbiter
  import dbus_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = DBUS_NUM_MASTERS,
  parameter int unsigned MAX_TENURE  = DBUS_MAX_TENURE,
  parameter int unsigned PARK_MASTER = 0
) (
  input  logic                              i_Clk,
  input  logic                              i_Rst,
  input  logic [NUM_MASTERS-1:0]            i_Req,
  input  logic [NUM_MASTERS-1:0]            i_Lock,
  output logic [NUM_MASTERS-1:0]            o_Gnt,
  output logic [idxWidth(NUM_MASTERS)-1:0]  o_GntIdx,
  output logic                              o_BusValid,
  output logic                              o_TenureExp
);

  localparam int unsigned IW = idxWidth(NUM_MASTERS);
  localparam int unsigned CW = tenureWidth(MAX_TENURE);
  localparam logic [IW-1:0]          PARK_IDX   = IW'(PARK_MASTER);
  localparam logic [NUM_MASTERS-1:0] PARK_GNT   = NUM_MASTERS'(1) << PARK_MASTER;
  localparam logic [CW-1:0]          TENURE_END = CW'(MAX_TENURE - 1);

  arbState_e             state;
  logic [IW-1:0]         nxtIdx;
  logic [CW-1:0]         tenureCnt;
  logic [NUM_MASTERS-1:0] arbReq;
  logic [IW-1:0]         pickIdx;
  logic [IW-1:0]         winIdx;
  logic                  pickValid;

  // The owner never competes against itself while granted, so one picker serves every decision.
  always_comb begin
    arbReq = i_Req;
    if (state == GRANTED) arbReq = i_Req & ~(NUM_MASTERS'(1) << o_GntIdx);
  end

  dbus_rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
    .req      (arbReq),
    .ptr      (o_GntIdx),
    .winIdx   (pickIdx),
    .winValid (pickValid)
  );

  always_comb begin
`ifdef DBUS_ARB_CPU_PRIORITY_EN
    winIdx = arbReq[PARK_MASTER] ? PARK_IDX : pickIdx;
`else
    winIdx = pickIdx;
`endif
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state       <= PARKED;
      o_Gnt       <= PARK_GNT;
      o_GntIdx    <= PARK_IDX;
      o_BusValid  <= 1'b1;
      o_TenureExp <= 1'b0;
      tenureCnt   <= '0;
      nxtIdx      <= PARK_IDX;
    end else begin
      o_TenureExp <= 1'b0;
      case (state)
        PARKED: begin
          if (pickValid) begin
            if (winIdx == PARK_IDX) begin
              state     <= GRANTED;
              tenureCnt <= '0;
            end else begin
              state      <= HANDOVER;
              nxtIdx     <= winIdx;
              o_Gnt      <= '0;
              o_BusValid <= 1'b0;
            end
          end
        end
        GRANTED: begin
          if (i_Req[o_GntIdx] && i_Lock[o_GntIdx]) begin
            if (tenureCnt != TENURE_END) tenureCnt <= tenureCnt + CW'(1);
          end else if (!i_Req[o_GntIdx]) begin
            if (pickValid) begin
              state      <= HANDOVER;
              nxtIdx     <= winIdx;
              o_Gnt      <= '0;
              o_BusValid <= 1'b0;
            end else if (o_GntIdx == PARK_IDX) begin
              state <= PARKED;
            end else begin
              state      <= HANDOVER;
              nxtIdx     <= PARK_IDX;
              o_Gnt      <= '0;
              o_BusValid <= 1'b0;
            end
          end else if (tenureCnt == TENURE_END && pickValid) begin
            state       <= HANDOVER;
            nxtIdx      <= winIdx;
            o_Gnt       <= '0;
            o_BusValid  <= 1'b0;
            o_TenureExp <= 1'b1;
          end else begin
            tenureCnt <= tenureCnt + CW'(1);
          end
        end
        HANDOVER: begin
          tenureCnt  <= '0;
          o_BusValid <= 1'b1;
          // A latched winner that dropped out is replaced by a fresh pick from the last owner.
          if (i_Req == '0) begin
            state    <= PARKED;
            o_GntIdx <= PARK_IDX;
            o_Gnt    <= PARK_GNT;
          end else if (i_Req[nxtIdx]) begin
            state    <= GRANTED;
            o_GntIdx <= nxtIdx;
            o_Gnt    <= NUM_MASTERS'(1) << nxtIdx;
          end else begin
            state    <= GRANTED;
            o_GntIdx <= winIdx;
            o_Gnt    <= NUM_MASTERS'(1) << winIdx;
          end
        end
        default: begin
          state      <= PARKED;
          o_Gnt      <= PARK_GNT;
          o_GntIdx   <= PARK_IDX;
          o_BusValid <= 1'b1;
          tenureCnt  <= '0;
        end
      endcase
    end
  end

  gntOneHot: assert property (@(posedge i_Clk) $onehot0(o_Gnt));

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed-vector bench for dbus_arbiter (4 masters, tenure 16, park on master 0).
module tb_dbus_arbiter;

  logic       i_Clk = 1'b0;
  logic       i_Rst;
  logic [3:0] i_Req;
  logic [3:0] i_Lock;
  logic [3:0] o_Gnt;
  logic [1:0] o_GntIdx;
  logic       o_BusValid;
  logic       o_TenureExp;

  int unsigned nVec = 0;
  int unsigned nMis = 0;

  always #5 i_Clk = ~i_Clk;

  dbus_arbiter #(
    .NUM_MASTERS (4),
    .MAX_TENURE  (16),
    .PARK_MASTER (0)
  ) dut (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_Req       (i_Req),
    .i_Lock      (i_Lock),
    .o_Gnt       (o_Gnt),
    .o_GntIdx    (o_GntIdx),
    .o_BusValid  (o_BusValid),
    .o_TenureExp (o_TenureExp)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    nVec++;
    if (got !== want) begin
      nMis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  // Packs {gnt, idx, busValid, tenureExp} so one vector covers the whole output state.
  task automatic checkBus(input string tag, input logic [3:0] gnt, input logic [1:0] idx,
                          input logic bv, input logic tx);
    checkVal(tag, {24'd0, o_Gnt, o_GntIdx, o_BusValid, o_TenureExp}, {24'd0, gnt, idx, bv, tx});
  endtask

  task automatic tick(input int unsigned n = 1);
    repeat (n) begin
      @(posedge i_Clk);
      #1;
    end
  endtask

  int unsigned owners [3] = '{1, 2, 3};
  logic [1:0]  prioWin;

  initial begin
    i_Rst  = 1'b1;
    i_Req  = 4'b0000;
    i_Lock = 4'b0000;
    tick(2);
    i_Rst = 1'b0;
    checkBus("reset", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      checkBus("idle_park", 4'b0001, 2'd0, 1'b1, 1'b0);
    end

    // Single non-park request: dead cycle, grant, release, dead cycle, park.
    i_Req = 4'b0100;
    tick();
    checkBus("park_to_ho", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    checkBus("grant2", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick(3);
    checkBus("hold2", 4'b0100, 2'd2, 1'b1, 1'b0);
    i_Req = 4'b0000;
    tick();
    checkBus("rel2_ho", 4'b0000, 2'd2, 1'b0, 1'b0);
    tick();
    checkBus("rel2_park", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Reset in the middle of a tenure goes straight back to park.
    i_Req = 4'b0010;
    tick(2);
    checkBus("grant1", 4'b0010, 2'd1, 1'b1, 1'b0);
    tick(4);
    i_Rst = 1'b1;
    i_Req = 4'b0000;
    tick();
    checkBus("rst_mid_tenure", 4'b0001, 2'd0, 1'b1, 1'b0);
    i_Rst = 1'b0;

    // Three masters held: 16-cycle tenures, expiry pulse in each dead cycle.
    i_Req = 4'b1110;
    tick();
    checkBus("rot_ho0", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      checkBus("rot_entry", 4'b0001 << owners[i], 2'(owners[i]), 1'b1, 1'b0);
      for (int k = 0; k < 15; k++) begin
        tick();
        checkBus("rot_hold", 4'b0001 << owners[i], 2'(owners[i]), 1'b1, 1'b0);
      end
      tick();
      checkBus("rot_expire", 4'b0000, 2'(owners[i]), 1'b0, 1'b1);
      tick();
    end
    checkBus("rot_wrap1", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Locked owner 3 holds past its tenure; dropping the lock forces expiry to 0.
    i_Req  = 4'b1001;
    i_Lock = 4'b1000;
    tick();
    checkBus("lock_ho", 4'b0000, 2'd1, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 40; k++) begin
      tick();
      checkBus("lock_hold", 4'b1000, 2'd3, 1'b1, 1'b0);
    end
    i_Lock = 4'b0000;
    tick();
    checkBus("lock_expire", 4'b0000, 2'd3, 1'b0, 1'b1);
    tick();
    checkBus("lock_to0", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Park master releasing with nobody waiting parks without a dead cycle.
    i_Req = 4'b0000;
    tick();
    checkBus("park_direct", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Latched winner 1 drops during the dead cycle; 2 is granted immediately.
    i_Req = 4'b0110;
    tick();
    checkBus("drop_ho", 4'b0000, 2'd0, 1'b0, 1'b0);
    i_Req = 4'b0100;
    tick();
    checkBus("drop_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);

    // Everyone requesting at owner 2's expiry: rotation picks 3, CPU priority picks 0.
    i_Req = 4'b1111;
    tick(15);
    checkBus("all_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick();
    checkBus("all_expire", 4'b0000, 2'd2, 1'b0, 1'b1);
    tick();
`ifdef DBUS_ARB_CPU_PRIORITY_EN
    prioWin = 2'd0;
`else
    prioWin = 2'd3;
`endif
    checkBus("all_winner", 4'b0001 << prioWin, prioWin, 1'b1, 1'b0);

    // Reset during a dead cycle also returns to park in one edge.
    i_Req = 4'b0100;
    tick();
    checkBus("ho_before_rst", 4'b0000, prioWin, 1'b0, 1'b0);
    i_Rst = 1'b1;
    i_Req = 4'b0000;
    tick();
    checkBus("rst_mid_ho", 4'b0001, 2'd0, 1'b1, 1'b0);
    i_Rst = 1'b0;
    tick();
    checkBus("post_rst_idle", 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
